sar_adc_ctrl: RTL and testbench



---
 rtl/sar_pkg.sv | 19 +
 rtl/sync_ff.sv | 23 ++
 rtl/sar_adc_ctrl.sv | 112 +++++++++++
 tb/tb_sar_adc_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and width helpers for the SAR ADC controller
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRIAL = 2'd1,
        ST_DONE  = 2'd2
    } sar_state_e;

    // Floor at one bit so degenerate parameter values still give a legal vector.
    function automatic int cnt_width(input int settle_cycles);
        return (settle_cycles > 2) ? $clog2(settle_cycles) : 1;
    endfunction

    function automatic int idx_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for an asynchronous single-bit input
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation controller driving an external R-2R DAC
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    parameter bit CMP_INV       = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(SETTLE_CYCLES);
    localparam int IW = idx_width(WIDTH);

    sar_state_e      state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic            cmp_sync;
    logic            cmp_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cmp_in),
        .q_o   (cmp_sync)
    );

    assign cmp_s = cmp_sync ^ CMP_INV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            dac_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dac_q    <= dac_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dac_d    = dac_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_TRIAL;
                    idx_d   = IW'(WIDTH - 1);
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
                    dac_d   = {1'b1, {(WIDTH-1){1'b0}}};
                end
            end
            ST_TRIAL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Decision cycle: cmp_s reflects a DAC level that has settled through the synchronizer.
                    if (!cmp_s) begin
                        dac_d[idx_q] = 1'b0;
                    end
                    if (idx_q != '0) begin
                        dac_d[idx_q - IW'(1)] = 1'b1;
                        idx_d = idx_q - IW'(1);
                        cnt_d = CW'(SETTLE_CYCLES - 1);
                    end else begin
                        state_d  = ST_DONE;
                        result_d = dac_d;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything; result keeps the last completed conversion.
        if (!ena) begin
            state_d  = ST_IDLE;
            dac_d    = '0;
            result_d = result_q;
        end
    end

    assign dac_code = dac_q;
    assign result   = result_q;
    assign busy     = (state_q == ST_TRIAL);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - self-checking bench for sar_adc_ctrl (normal and inverted comparator sense)
module tb_sar_adc_ctrl;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena   = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] vin   = '0;

    logic         cmp0, cmp1;
    logic [W-1:0] dac0, res0, dac1, res1;
    logic         busy0, done0, busy1, done1;

    logic [W-1:0] exp_trial [W];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Ideal comparator; the second instance sees the opposite sense and undoes it with CMP_INV.
    assign cmp0 = (vin >= dac0);
    assign cmp1 = !(vin >= dac1);

    sar_adc_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S), .SYNC_STAGES(2), .CMP_INV(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .cmp_in   (cmp0),
        .dac_code (dac0),
        .result   (res0),
        .busy     (busy0),
        .done     (done0)
    );

    sar_adc_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S), .SYNC_STAGES(2), .CMP_INV(1'b1)) dut_inv (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .cmp_in   (cmp1),
        .dac_code (dac1),
        .result   (res1),
        .busy     (busy1),
        .done     (done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Binary search over the code space: each trial adds the next bit to the best code so far.
    task automatic build_model(input logic [W-1:0] v);
        logic [W-1:0] code;
        logic [W-1:0] trial;
        code = '0;
        for (int k = 0; k < W; k++) begin
            trial = code | W'(1 << (W - 1 - k));
            exp_trial[k] = trial;
            if (v >= trial) code = trial;
        end
    endtask

    task automatic convert(input logic [W-1:0] v, input int t1, input int t2,
                           input int abort_at, input logic [W-1:0] exp_res);
        int   nb0, nb1, nd0, nd1;
        logic aborted;
        nb0 = 0; nb1 = 0; nd0 = 0; nd1 = 0;
        aborted = 1'b0;
        build_model(v);
        vin = v;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy0) nb0++;
            if (busy1) nb1++;
            if (done0) nd0++;
            if (done1) nd1++;
            if (!aborted && c < W*S) begin
                chk("trial_code", 32'(dac0), 32'(exp_trial[c/S]));
                chk("trial_code_inv", 32'(dac1), 32'(exp_trial[c/S]));
            end
            if (aborted && c == abort_at + 1) begin
                chk("abort_busy", 32'(busy0), 32'd0);
                chk("abort_dac", 32'(dac0), 32'd0);
                chk("abort_busy_inv", 32'(busy1), 32'd0);
                chk("abort_dac_inv", 32'(dac1), 32'd0);
                ena = 1'b1;
            end
            if (abort_at < 0 && c == W*S) begin
                chk("done_pulse", 32'(done0), 32'd1);
                chk("done_result", 32'(res0), 32'(v));
                chk("final_dac", 32'(dac0), 32'(v));
                chk("done_pulse_inv", 32'(done1), 32'd1);
                chk("done_result_inv", 32'(res1), 32'(v));
            end
            start = (c == t1 || c == t2);
            if (c == abort_at) begin
                ena = 1'b0;
                aborted = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_cycles", 32'(nb0), (abort_at >= 0) ? 32'(abort_at + 1) : 32'(W*S));
        chk("busy_cycles_inv", 32'(nb1), (abort_at >= 0) ? 32'(abort_at + 1) : 32'(W*S));
        chk("done_count", 32'(nd0), (abort_at >= 0) ? 32'd0 : 32'd1);
        chk("done_count_inv", 32'(nd1), (abort_at >= 0) ? 32'd0 : 32'd1);
        chk("result_hold", 32'(res0), 32'(exp_res));
        chk("result_hold_inv", 32'(res1), 32'(exp_res));
    endtask

    initial begin
        logic [W-1:0] r;

        repeat (2) @(negedge clk);
        chk("rst_dac", 32'(dac0), 32'd0);
        chk("rst_result", 32'(res0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        rst_n = 1'b1;
        ena   = 1'b1;
        @(negedge clk);

        convert(8'hA5, -1, -1, -1, 8'hA5);
        convert(8'h00, -1, -1, -1, 8'h00);
        convert(8'hFF, -1, -1, -1, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            r = W'($urandom_range(0, 255));
            convert(r, -1, -1, -1, r);
        end
        convert(8'h3C, 5, 20, -1, 8'h3C);
        r = W'($urandom_range(0, 255));
        convert(r, -1, -1, 10, 8'h3C);

        vin = 8'h77;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy0), 32'd0);
        chk("async_rst_dac", 32'(dac0), 32'd0);
        chk("async_rst_result", 32'(res0), 32'd0);
        chk("async_rst_done", 32'(done0), 32'd0);
        chk("async_rst_dac_inv", 32'(dac1), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        convert(8'h5A, -1, -1, -1, 8'h5A);
        convert(8'h81, -1, -1, -1, 8'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
